// File: rtl/key_search_pkg.sv
// Shared types and constants for the brute-force DES key search sequencer.
package key_search_pkg;

  // DES block width and the width of a DES key without its parity bits.
  localparam int DES_W    = 64;
  localparam int KEY_BITS = 56;

  // Known plaintext of the target file: "%pdf%pdf".
  localparam logic [DES_W-1:0] PLAIN_DEFAULT = 64'h2570_6466_2570_6466;

  // Sequencer states. The encoding is also what the debug state port reports.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_CIPHER = 3'd1,
    ST_ISSUE       = 3'd2,
    ST_WAIT_CORE   = 3'd3,
    ST_CHECK       = 3'd4,
    ST_FOUND       = 3'd5,
    ST_EXHAUSTED   = 3'd6
  } state_e;

endpackage

// File: rtl/key_search_ctrl_if.sv
// Bundle of every non-clock signal of key_search_ctrl.
// The slave modport is the sequencer itself; the master modport is its
// environment (file reader, DES core and status consumer together).
//
// Handshakes: start/abort are one-cycle pulses sampled on the rising edge.
// cipher_valid is a level; cipher_in is taken on the first edge it is high
// while the sequencer waits for it. des_start is a one-cycle request and
// des_key/des_data stay stable until the core answers with a one-cycle
// des_done pulse, des_result valid in that same cycle.
interface key_search_ctrl_if #(
  parameter int KEY_W = 56
);
  logic             start;
  logic             abort;
  logic             cipher_valid;
  logic [63:0]      cipher_in;
  logic             des_start;
  logic [63:0]      des_key;
  logic [63:0]      des_data;
  logic             des_done;
  logic [63:0]      des_result;
  logic             busy;
  logic             found;
  logic             exhausted;
  logic [KEY_W-1:0] key_out;
  logic [KEY_W:0]   tries;
  logic [2:0]       dbg_state;

  modport master (
    output start, abort, cipher_valid, cipher_in, des_done, des_result,
    input  des_start, des_key, des_data, busy, found, exhausted,
           key_out, tries, dbg_state
  );

  modport slave (
    input  start, abort, cipher_valid, cipher_in, des_done, des_result,
    output des_start, des_key, des_data, busy, found, exhausted,
           key_out, tries, dbg_state
  );
endinterface

// File: rtl/key_expand.sv
// Combinational 56->64 DES key expansion. Byte i (byte 0 is the MSB) carries
// seven key bits followed by a low-order bit.
// Build option KEY_PARITY_EN: when defined, the low-order bit of each byte is
// odd parity over the byte's seven key bits; otherwise it is 0. The DES core
// ignores these bits, so the option only changes what is seen on des_key.
module key_expand
  import key_search_pkg::*;
(
  input  logic [KEY_BITS-1:0] key_i,
  output logic [DES_W-1:0]    des_key_o
);

  // Spread the key seven bits per byte and fill in the low-order bit.
  always_comb begin
    des_key_o = '0;
    for (int i = 0; i < 8; i++) begin
      des_key_o[DES_W-1-8*i -: 7] = key_i[KEY_BITS-1-7*i -: 7];
`ifdef KEY_PARITY_EN
      des_key_o[DES_W-8-8*i] = ~(^key_i[KEY_BITS-1-7*i -: 7]);
`endif
    end
  end

endmodule

// File: rtl/key_search_ctrl.sv
// Brute-force key search sequencer. Waits for the file reader's ciphertext,
// walks candidate keys KEY_FIRST..KEY_LAST through the DES core one at a
// time and stops on a plaintext match, on the last key, or on abort.
// Build option KEY_PARITY_EN (see key_expand) selects parity bits in des_key.
module key_search_ctrl
  import key_search_pkg::*;
#(
  parameter int               KEY_W     = 56,
  parameter logic [KEY_W-1:0] KEY_FIRST = '0,
  parameter logic [KEY_W-1:0] KEY_LAST  = '1,
  parameter logic [DES_W-1:0] PLAIN     = PLAIN_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  key_search_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE        = ST_IDLE;
  localparam logic [2:0] S_WAIT_CIPHER = ST_WAIT_CIPHER;
  localparam logic [2:0] S_ISSUE       = ST_ISSUE;
  localparam logic [2:0] S_WAIT_CORE   = ST_WAIT_CORE;
  localparam logic [2:0] S_CHECK       = ST_CHECK;
  localparam logic [2:0] S_FOUND       = ST_FOUND;
  localparam logic [2:0] S_EXHAUSTED   = ST_EXHAUSTED;

  logic [2:0]       state_q,  state_d;
  logic [KEY_W-1:0] key_q,    key_d;
  logic [DES_W-1:0] data_q,   data_d;
  logic [DES_W-1:0] result_q, result_d;
  logic [KEY_W:0]   tries_q,  tries_d;

  // Next-state logic; abort wins over everything, including the CHECK
  // decision and a des_done arriving in the same cycle.
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    data_d   = data_q;
    result_d = result_q;
    tries_d  = tries_q;
    if (bus.abort) begin
      state_d = S_IDLE;
      key_d   = KEY_FIRST;
    end else begin
      case (state_q)
        S_IDLE, S_FOUND, S_EXHAUSTED: begin
          if (bus.start) begin
            state_d = S_WAIT_CIPHER;
            key_d   = KEY_FIRST;
            tries_d = '0;
          end
        end
        S_WAIT_CIPHER: begin
          if (bus.cipher_valid) begin
            data_d  = bus.cipher_in;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_d = S_WAIT_CORE;
        end
        S_WAIT_CORE: begin
          if (bus.des_done) begin
            result_d = bus.des_result;
            tries_d  = tries_q + (KEY_W+1)'(1);
            state_d  = S_CHECK;
          end
        end
        S_CHECK: begin
          if (result_q == PLAIN) begin
            state_d = S_FOUND;
          end else if (key_q == KEY_LAST) begin
            // Stop on the last key rather than wrapping the counter.
            state_d = S_EXHAUSTED;
          end else begin
            key_d   = key_q + KEY_W'(1);
            state_d = S_ISSUE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      key_q    <= KEY_FIRST;
      data_q   <= '0;
      result_q <= '0;
      tries_q  <= '0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      data_q   <= data_d;
      result_q <= result_d;
      tries_q  <= tries_d;
    end
  end

  key_expand u_key_expand (
    .key_i     (KEY_BITS'(key_q)),
    .des_key_o (bus.des_key)
  );

  // Moore outputs decoded from the state register.
  assign bus.des_start = (state_q == S_ISSUE);
  assign bus.busy      = (state_q == S_WAIT_CIPHER) || (state_q == S_ISSUE) ||
                         (state_q == S_WAIT_CORE)   || (state_q == S_CHECK);
  assign bus.found     = (state_q == S_FOUND);
  assign bus.exhausted = (state_q == S_EXHAUSTED);
  assign bus.des_data  = data_q;
  assign bus.key_out   = key_q;
  assign bus.tries     = tries_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_key_search_ctrl.sv
// Bench for key_search_ctrl: a default-range instance (keys from 0) and a
// single-key instance at the top of the key space, each with a behavioural
// DES core that answers L cycles after a request and decrypts to the known
// plaintext only for a chosen secret key.
module tb_key_search_ctrl;
  import key_search_pkg::*;

  localparam logic [55:0] ONES56 = 56'hFF_FFFF_FFFF_FFFF;
  localparam int          BUDGET = 600;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  key_search_ctrl_if #(.KEY_W(56)) ia ();
  key_search_ctrl_if #(.KEY_W(56)) ib ();

  key_search_ctrl u_a (.clk(clk), .rst(rst), .bus(ia));
  key_search_ctrl #(.KEY_FIRST(ONES56), .KEY_LAST(ONES56)) u_b (.clk(clk), .rst(rst), .bus(ib));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Recover the 56 key bits from a 64-bit DES key.
  function automatic logic [55:0] strip(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[55-7*i -: 7] = k[63-8*i -: 7];
    return r;
  endfunction

  // Behavioural DES cores: a request seen in cycle c is answered in cycle c+L.
  int          a_L, b_L, a_cnt, b_cnt;
  logic [55:0] a_match, b_match, a_cand, b_cand;

  always @(negedge clk) begin
    if (rst) begin
      a_cnt = 0; ia.des_done = 1'b0; ia.des_result = '0;
    end else begin
      ia.des_done = 1'b0;
      if (a_cnt > 0) begin
        a_cnt--;
        if (a_cnt == 0) begin
          ia.des_done   = 1'b1;
          ia.des_result = (a_cand == a_match) ? PLAIN_DEFAULT : ~PLAIN_DEFAULT;
        end
      end
      if (ia.des_start) begin a_cnt = a_L; a_cand = strip(ia.des_key); end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      b_cnt = 0; ib.des_done = 1'b0; ib.des_result = '0;
    end else begin
      ib.des_done = 1'b0;
      if (b_cnt > 0) begin
        b_cnt--;
        if (b_cnt == 0) begin
          ib.des_done   = 1'b1;
          ib.des_result = (b_cand == b_match) ? PLAIN_DEFAULT : ~PLAIN_DEFAULT;
        end
      end
      if (ib.des_start) begin b_cnt = b_L; b_cand = strip(ib.des_key); end
    end
  end

  // Scoreboard compare
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  typedef struct {
    int L; int m; int d; bit poke;
    int exp_tries; int exp_key; int exp_cyc;
  } vec_t;

  bit parity_done;

  // One search on the default instance. Cycle 0 is the cycle carrying start.
  task automatic run_search(input int L, input int m, input int d, input bit poke,
                            input int exp_tries, input int exp_key, input int exp_cyc);
    logic [63:0] cipher;
    int cyc, first_issue;
    bit busy_ok;
    cipher = {$urandom, $urandom};
    a_L = L; a_match = 56'(m);
    ia.cipher_in = cipher;
    ia.cipher_valid = (d == 0);
    ia.start = 1'b1;
    step();
    ia.start = 1'b0;
    cyc = 1; first_issue = -1; busy_ok = 1'b1;
    check("start_tries_clear", 64'(ia.tries), 64'd0);
    check("start_key_first", 64'(ia.key_out), 64'd0);
    while (!(ia.found || ia.exhausted) && cyc < BUDGET) begin
      if (cyc == 1 + d) ia.cipher_valid = 1'b1;
      if (ia.des_start && first_issue < 0) first_issue = cyc;
      if (poke) ia.start = (first_issue >= 0 && cyc == first_issue + 1);
      if (!ia.busy) busy_ok = 1'b0;
      if (!parity_done && ia.des_start && ia.key_out == 56'd1) begin
        parity_done = 1'b1;
`ifdef KEY_PARITY_EN
        check("des_key_key1", ia.des_key, 64'h01010101_01010102);
`else
        check("des_key_key1", ia.des_key, 64'h00000000_00000002);
`endif
      end
      step();
      cyc++;
    end
    ia.start = 1'b0;
    check("search_timeout", 64'(cyc < BUDGET), 64'd1);
    check("found", 64'(ia.found), 64'd1);
    check("exhausted_low", 64'(ia.exhausted), 64'd0);
    check("busy_low_at_end", 64'(ia.busy), 64'd0);
    check("tries", 64'(ia.tries), 64'(exp_tries));
    check("key_out", 64'(ia.key_out), 64'(exp_key));
    check("found_cycle", 64'(cyc), 64'(exp_cyc));
    check("first_des_start", 64'(first_issue), 64'(2 + d));
    check("busy_throughout", 64'(busy_ok), 64'd1);
    check("des_data", ia.des_data, cipher);
  endtask

  vec_t tbl[5];

  initial begin
    int cyc;
    checks = 0; failures = 0; parity_done = 1'b0;
    a_L = 3; b_L = 2; a_match = '0; b_match = '0; a_cand = '0; b_cand = '0;
    ia.start = 0; ia.abort = 0; ia.cipher_valid = 0; ia.cipher_in = '0;
    ib.start = 0; ib.abort = 0; ib.cipher_valid = 0; ib.cipher_in = '0;
    rst = 1'b1;
    repeat (3) step();
    check("rst_key_out", 64'(ia.key_out), 64'd0);
    check("rst_des_data", ia.des_data, 64'd0);
    check("rst_tries", 64'(ia.tries), 64'd0);
    check("rst_flags", {60'd0, ia.des_start, ia.busy, ia.found, ia.exhausted}, 64'd0);
    check("rst_b_key_out", 64'(ib.key_out), 64'(ONES56));
    rst = 1'b0;
    step();
    check("idle_flags", {60'd0, ia.des_start, ia.busy, ia.found, ia.exhausted}, 64'd0);

    // Directed table: found cycle = 2 + delay + tries*(L+2)
    tbl[0] = '{3, 5, 0,  1'b0, 6, 5, 32};
    tbl[1] = '{2, 0, 0,  1'b0, 1, 0, 6};
    tbl[2] = '{4, 3, 10, 1'b0, 4, 3, 36};
    tbl[3] = '{3, 2, 0,  1'b1, 3, 2, 17};
    tbl[4] = '{1, 4, 2,  1'b0, 5, 4, 19};
    for (int i = 0; i < 5; i++) begin
      run_search(tbl[i].L, tbl[i].m, tbl[i].d, tbl[i].poke,
                 tbl[i].exp_tries, tbl[i].exp_key, tbl[i].exp_cyc);
      repeat (2) step();
      check("found_holds", 64'(ia.found), 64'd1);
    end

    // Randomized searches against the reference timing/count model.
    for (int r = 0; r < 8; r++) begin
      int L, m, d;
      L = $urandom_range(1, 6); m = $urandom_range(0, 9); d = $urandom_range(0, 5);
      run_search(L, m, d, 1'($urandom_range(0, 1)), m + 1, m, 2 + d + (m + 1) * (L + 2));
    end

    // Abort in the same cycle as des_done for the matching key.
    a_L = 3; a_match = 56'd2; ia.cipher_valid = 1'b1;
    ia.start = 1'b1; step(); ia.start = 1'b0;
    cyc = 0;
    while (!(ia.des_done && a_cand == 56'd2) && cyc < BUDGET) begin step(); cyc++; end
    check("abort_wait_timeout", 64'(cyc < BUDGET), 64'd1);
    ia.abort = 1'b1;
    step();
    ia.abort = 1'b0;
    check("abort_idle", {61'd0, ia.busy, ia.found, ia.exhausted}, 64'd0);
    check("abort_key_first", 64'(ia.key_out), 64'd0);
    check("abort_tries_held", 64'(ia.tries), 64'd2);
    repeat (8) step();
    check("abort_stays_idle", {61'd0, ia.busy, ia.found, ia.exhausted}, 64'd0);

    // Single-key range at the top of the key space, never matching.
    ib.cipher_valid = 1'b1; ib.cipher_in = 64'h0123_4567_89AB_CDEF;
    ib.start = 1'b1; step(); ib.start = 1'b0;
    cyc = 1;
    while (!(ib.found || ib.exhausted) && cyc < BUDGET) begin step(); cyc++; end
    check("b_timeout", 64'(cyc < BUDGET), 64'd1);
    check("b_exhausted", 64'(ib.exhausted), 64'd1);
    check("b_found_low", 64'(ib.found), 64'd0);
    check("b_cycle", 64'(cyc), 64'd6);
    check("b_tries", 64'(ib.tries), 64'd1);
    check("b_key_no_wrap", 64'(ib.key_out), 64'(ONES56));
    repeat (5) step();
    check("b_hold_exhausted", 64'(ib.exhausted), 64'd1);
    check("b_hold_key", 64'(ib.key_out), 64'(ONES56));
    check("b_hold_tries", 64'(ib.tries), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
